// File: rtl/simplez_loader.sv
// simplez_loader: receives a framed program image from the UART receiver and
// packs each HI/LO byte pair into one instruction word. Each word is written
// through the program memory write port. The Simplez core is held in reset
// while a frame loads and is released only after the checksum matches.
//
// Frame: START_BYTE, CNT_H, CNT_L, N x (HI, LO), CHK (mod-256 sum of data bytes)
//
// Ports:
//   clk       system clock
//   rstn      synchronous reset, active low
//   rx_data   received byte
//   rx_rcv    one-cycle strobe, rx_data valid
//   mem_we    program memory write enable (one-cycle pulse)
//   mem_addr  program memory write address
//   mem_din   program memory write data
//   cpu_rstn  reset to the Simplez core, active low
//   busy      frame in progress
//   err       sticky frame error flag
//   done      one-cycle pulse on successful load
//
// state   | meaning
// IDLE    | waiting for START_BYTE, other bytes ignored
// CNT_H   | expecting word count high byte
// CNT_L   | expecting word count low byte
// DATA_H  | expecting high byte of a word
// DATA_L  | expecting low byte of a word, triggers the memory write
// CHK     | expecting checksum byte
// ERR     | frame failed, core held in reset until the next START_BYTE
module simplez_loader #(
  parameter int          AW         = 9,
  parameter int          DW         = 12,
  parameter logic [7:0]  START_BYTE = 8'h4C,
  parameter logic [23:0] TIMEOUT    = 24'd12_000_000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data,
  input  logic          rx_rcv,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          err,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L, S_CHK, S_ERR
  } state_t;

  localparam logic [16:0] MAX_N    = 17'(1) << AW;
  localparam logic [23:0] TMO_LOAD = TIMEOUT - 24'd1;

  state_t          state_q, state_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            cpu_rstn_q, cpu_rstn_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [7:0]      csum_q, csum_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [23:0]     tmo_q, tmo_d;
  logic [DW-9:0]   hi_q, hi_d;
  logic            in_frame;
  logic [15:0]     n_rx;

  assign in_frame = (state_q == S_CNT_H) || (state_q == S_CNT_L) ||
                    (state_q == S_DATA_H) || (state_q == S_DATA_L) ||
                    (state_q == S_CHK);
  assign n_rx = {cnt_q[15:8], rx_data};

  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    // the address advances the cycle after each write pulse
    mem_addr_d = mem_we_q ? mem_addr_q + AW'(1) : mem_addr_q;
    mem_din_d  = mem_din_q;
    cpu_rstn_d = cpu_rstn_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = 1'b0;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    tmo_d      = tmo_q;
    hi_d       = hi_q;

    // inter-byte watchdog: reload on every byte, expire at zero
    if (in_frame) begin
      if (rx_rcv) begin
        tmo_d = TMO_LOAD;
      end else if (tmo_q == 24'd0) begin
        state_d = S_ERR;
        err_d   = 1'b1;
        busy_d  = 1'b0;
      end else begin
        tmo_d = tmo_q - 24'd1;
      end
    end

    if (rx_rcv) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (rx_data == START_BYTE) begin
            state_d    = S_CNT_H;
            cpu_rstn_d = 1'b0;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            csum_d     = 8'd0;
            mem_addr_d = '0;
            wcnt_d     = 16'd0;
            tmo_d      = TMO_LOAD;
          end
        end
        S_CNT_H: begin
          cnt_d[15:8] = rx_data;
          state_d     = S_CNT_L;
        end
        S_CNT_L: begin
          cnt_d = n_rx;
          if ({1'b0, n_rx} > MAX_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (n_rx == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_H;
          end
        end
        S_DATA_H: begin
          hi_d    = rx_data[DW-9:0];
          csum_d  = csum_q + rx_data;
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          mem_din_d = {hi_q, rx_data};
          mem_we_d  = 1'b1;
          csum_d    = csum_q + rx_data;
          wcnt_d    = wcnt_q + 16'd1;
          state_d   = (wcnt_q + 16'd1 == cnt_q) ? S_CHK : S_DATA_H;
        end
        S_CHK: begin
          busy_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d    = S_IDLE;
            cpu_rstn_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_rstn_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      csum_q     <= 8'd0;
      cnt_q      <= 16'd0;
      wcnt_q     <= 16'd0;
      tmo_q      <= 24'd0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_q     <= done_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      tmo_q      <= tmo_d;
      hi_q       <= hi_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign cpu_rstn = cpu_rstn_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign done     = done_q;

endmodule
